// File: rtl/div_sequencer.sv
// Multi-cycle restoring divide/remainder unit for DIV/DIVU/REM/REMU and their W forms.
// Sequenced as IDLE -> PREP -> ITER (one quotient bit per cycle) -> FIX -> DONE.
module div_sequencer #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_dividend,
    input  logic [XLEN-1:0] req_divisor,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            busy
);

    localparam int unsigned WLEN = 32;
    localparam int unsigned CW   = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [1:0]      r_op;
    logic            r_word;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_q;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_data;

    logic            w_req_ready;
    logic            w_accept;
    logic            w_signed;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_min;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN+1:0] w_rem_sh;
    logic [XLEN+1:0] w_rem_sub;
    logic            w_ge;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_fix_res;

    // Pick quotient or remainder; W results are always sign-extended from bit 31.
    function automatic logic [XLEN-1:0] f_select(input logic is_rem, input logic word,
                                                 input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r);
        logic [XLEN-1:0] res;
        res = is_rem ? r : q;
        if (word) begin
            res = {{(XLEN-WLEN){res[WLEN-1]}}, res[WLEN-1:0]};
        end
        return res;
    endfunction

    assign w_req_ready = (r_state == S_IDLE) && !flush && !reset;
    assign w_accept    = req_valid && w_req_ready;

    // Operand conditioning, evaluated while in PREP from the latched request.
    assign w_signed = ~r_op[0];
    assign w_a_ext  = r_word ? (w_signed ? {{(XLEN-WLEN){r_a[WLEN-1]}}, r_a[WLEN-1:0]}
                                         : {{(XLEN-WLEN){1'b0}}, r_a[WLEN-1:0]})
                             : r_a;
    assign w_b_ext  = r_word ? (w_signed ? {{(XLEN-WLEN){r_b[WLEN-1]}}, r_b[WLEN-1:0]}
                                         : {{(XLEN-WLEN){1'b0}}, r_b[WLEN-1:0]})
                             : r_b;
    assign w_a_neg  = w_signed && w_a_ext[XLEN-1];
    assign w_b_neg  = w_signed && w_b_ext[XLEN-1];
    assign w_a_mag  = w_a_neg ? (-w_a_ext) : w_a_ext;
    assign w_b_mag  = w_b_neg ? (-w_b_ext) : w_b_ext;

    // Most-negative value at the operation width, after word sign-extension.
    assign w_min      = r_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                               : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero = (w_b_ext == '0);
    assign w_ovf      = w_signed && (w_b_ext == '1) && (w_a_ext == w_min);
    assign w_special  = w_div_zero || w_ovf;
    assign w_spec_res = f_select(r_op[1], r_word,
                                 w_div_zero ? '1 : w_a_ext,
                                 w_div_zero ? w_a_ext : '0);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_rem_sh  = {r_rem, r_q[XLEN-1]};
    assign w_rem_sub = w_rem_sh - {2'b00, r_div};
    assign w_ge      = (w_rem_sh >= {2'b00, r_div});

    assign w_q_fix   = r_neg_q ? (-r_q) : r_q;
    assign w_r_fix   = r_neg_r ? (-r_rem[XLEN-1:0]) : r_rem[XLEN-1:0];
    assign w_fix_res = f_select(r_op[1], r_word, w_q_fix, w_r_fix);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush overrides every non-idle transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_PREP;
            S_PREP: w_next = w_special ? S_DONE : S_ITER;
            S_ITER: if (r_cnt == CW'(1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    // Output decode from the registered state and datapath.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        resp_data  = r_data;
        resp_rd    = r_rd;
        req_ready  = w_req_ready;
        resp_valid = (r_state == S_DONE);
        busy       = (r_state != S_IDLE);
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= '0;
            r_word  <= 1'b0;
            r_rd    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= req_op;
                        r_word <= req_word;
                        r_rd   <= req_rd;
                        r_a    <= req_dividend;
                        r_b    <= req_divisor;
                    end
                end
                S_PREP: begin
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_div   <= w_b_mag;
                    r_q     <= r_word ? (w_a_mag << (XLEN-WLEN)) : w_a_mag;
                    r_rem   <= '0;
                    r_cnt   <= r_word ? CW'(WLEN) : CW'(XLEN);
                    if (w_special) begin
                        r_data <= w_spec_res;
                    end
                end
                S_ITER: begin
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                    r_rem <= w_ge ? (XLEN+1)'(w_rem_sub) : (XLEN+1)'(w_rem_sh);
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_data <= w_fix_res;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
